uart_rx_frontend: RTL and testbench

//   Serial receive front end of ecap5_wbuart. Synchronises uart_rx_i and

---
 rtl/uart_rx_frontend.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// UART receive front end: synchronises the serial line, validates the start bit and
// samples data/parity/stop bits at mid-bit, emitting one rx_valid_o pulse per frame.
module uart_rx_frontend #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             frontend_rst_i,
  input  logic [DIV_W-1:0] cr_clk_div_i,
  input  logic [1:0]       cr_ds_i,
  input  logic             cr_s_i,
  input  logic [1:0]       cr_p_i,
  input  logic             uart_rx_i,
  output logic [7:0]       rx_frame_o,
  output logic             rx_parity_o,
  output logic             rx_frame_err_o,
  output logic             rx_valid_o
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned MIN_DIV = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e             state_q;
  state_e             state_d;

  logic               srst_c;
  logic [1:0]         sync_q;
  logic               rx_s_c;
  logic               rx_prev_q;
  logic               fall_c;

  logic [DIV_W-1:0]   div_in_c;
  logic [DIV_W-1:0]   half_c;
  logic [DIV_W-1:0]   div_q;
  logic [1:0]         ds_q;
  logic               s_q;
  logic [1:0]         p_q;

  logic [DIV_W-1:0]   cnt_q;
  logic               strobe_c;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   last_idx_c;
  logic               last_stop_c;
  logic               stop_first_q;

  logic [DATA_W-1:0]  data_q;
  logic               par_q;
  logic               err_q;

  logic               start_c;
  logic               load_c;
  logic [DIV_W-1:0]   load_val_c;
  logic               shift_c;
  logic               par_c;
  logic               stop_c;
  logic               done_c;

  assign srst_c = rst_i | frontend_rst_i;
  assign rx_s_c = sync_q[1];
  assign fall_c = rx_prev_q & ~rx_s_c;

  // Divider values below MIN_DIV would leave no room for a half-bit delay
  assign div_in_c   = (cr_clk_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cr_clk_div_i;
  assign half_c     = (div_in_c >> 1) - DIV_W'(1);
  assign strobe_c   = (cnt_q == '0);
  assign last_idx_c = IDX_W'(3'd7 - {1'b0, ds_q});
  assign last_stop_c = ~s_q | stop_first_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (srst_c) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fall_c) state_d = START;
      end
      START: begin
        if (strobe_c) state_d = rx_s_c ? IDLE : DATA;
      end
      DATA: begin
        if (strobe_c && (idx_q == last_idx_c)) state_d = p_q[1] ? PARITY : STOP;
      end
      PARITY: begin
        if (strobe_c) state_d = STOP;
      end
      STOP: begin
        if (strobe_c && last_stop_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-state datapath controls
  always_comb begin
    start_c    = 1'b0;
    load_c     = 1'b0;
    load_val_c = div_q - DIV_W'(1);
    shift_c    = 1'b0;
    par_c      = 1'b0;
    stop_c     = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_c) begin
          start_c    = 1'b1;
          load_c     = 1'b1;
          load_val_c = half_c;
        end
      end
      START: begin
        if (strobe_c) load_c = 1'b1;
      end
      DATA: begin
        if (strobe_c) begin
          shift_c = 1'b1;
          load_c  = 1'b1;
        end
      end
      PARITY: begin
        if (strobe_c) begin
          par_c  = 1'b1;
          load_c = 1'b1;
        end
      end
      STOP: begin
        if (strobe_c) begin
          stop_c = 1'b1;
          if (last_stop_c) done_c = 1'b1;
          else             load_c = 1'b1;
        end
      end
      default: begin
        start_c = 1'b0;
      end
    endcase
  end

  // Synchroniser, configuration latch, bit timer and frame assembly
  always_ff @(posedge clk_i) begin
    if (srst_c) begin
      sync_q         <= 2'b11;
      rx_prev_q      <= 1'b1;
      div_q          <= DIV_W'(MIN_DIV);
      ds_q           <= 2'b00;
      s_q            <= 1'b0;
      p_q            <= 2'b00;
      cnt_q          <= '0;
      idx_q          <= '0;
      stop_first_q   <= 1'b0;
      data_q         <= '0;
      par_q          <= 1'b0;
      err_q          <= 1'b0;
      rx_frame_o     <= '0;
      rx_parity_o    <= 1'b0;
      rx_frame_err_o <= 1'b0;
      rx_valid_o     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], uart_rx_i};
      rx_prev_q <= rx_s_c;

      if (load_c) begin
        cnt_q <= load_val_c;
      end else if (!strobe_c) begin
        cnt_q <= cnt_q - DIV_W'(1);
      end

      if (start_c) begin
        div_q        <= div_in_c;
        ds_q         <= cr_ds_i;
        s_q          <= cr_s_i;
        p_q          <= cr_p_i;
        idx_q        <= '0;
        stop_first_q <= 1'b0;
        data_q       <= '0;
        par_q        <= 1'b0;
        err_q        <= 1'b0;
      end

      if (shift_c) begin
        data_q[idx_q] <= rx_s_c;
        idx_q         <= idx_q + IDX_W'(1);
      end

      if (par_c) par_q <= rx_s_c;

      if (stop_c) begin
        err_q        <= err_q | ~rx_s_c;
        stop_first_q <= 1'b1;
      end

      rx_valid_o <= done_c;
      if (done_c) begin
        rx_frame_o     <= data_q;
        rx_parity_o    <= par_q;
        rx_frame_err_o <= err_q | ~rx_s_c;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: drives serial frames from the bench side and
// checks frame contents, error flag, parity and pulse latency against hand values.
module tb_uart_rx_frontend;

  localparam int unsigned DIV_W = 16;
  localparam int          SYNC_LAT = 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             frontend_rst_i;
  logic [DIV_W-1:0] cr_clk_div_i;
  logic [1:0]       cr_ds_i;
  logic             cr_s_i;
  logic [1:0]       cr_p_i;
  logic             uart_rx_i;
  logic [7:0]       rx_frame_o;
  logic             rx_parity_o;
  logic             rx_frame_err_o;
  logic             rx_valid_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         pulse_q[$];
  int         fall_q[$];
  logic [7:0] frame_q[$];
  logic       err_q[$];
  logic       par_q[$];

  uart_rx_frontend #(.DIV_W(DIV_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .frontend_rst_i (frontend_rst_i),
    .cr_clk_div_i   (cr_clk_div_i),
    .cr_ds_i        (cr_ds_i),
    .cr_s_i         (cr_s_i),
    .cr_p_i         (cr_p_i),
    .uart_rx_i      (uart_rx_i),
    .rx_frame_o     (rx_frame_o),
    .rx_parity_o    (rx_parity_o),
    .rx_frame_err_o (rx_frame_err_o),
    .rx_valid_o     (rx_valid_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record every cycle in which rx_valid_o is high
  always @(negedge clk_i) begin
    if (rx_valid_o === 1'b1) begin
      pulse_q.push_back(cyc);
      frame_q.push_back(rx_frame_o);
      err_q.push_back(rx_frame_err_o);
      par_q.push_back(rx_parity_o);
    end
  end

  task automatic clear_mon();
    pulse_q.delete();
    fall_q.delete();
    frame_q.delete();
    err_q.delete();
    par_q.delete();
  endtask

  task automatic set_cfg(input int div, input logic [1:0] ds, input logic s, input logic [1:0] p);
    cr_clk_div_i = DIV_W'(div);
    cr_ds_i      = ds;
    cr_s_i       = s;
    cr_p_i       = p;
  endtask

  task automatic hold_line(input logic b, input int cycles);
    uart_rx_i = b;
    repeat (cycles) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit par_en,
                            input logic par_bit, input int nstop, input int div);
    fall_q.push_back(cyc);
    hold_line(1'b0, div);
    for (int i = 0; i < nbits; i++) hold_line(data[i], div);
    if (par_en) hold_line(par_bit, div);
    for (int i = 0; i < nstop; i++) hold_line(1'b1, div);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    frontend_rst_i = 1'b0;
    uart_rx_i = 1'b1;
    set_cfg(16, 2'b00, 1'b0, 2'b00);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid_o); end
    n_checks++;
    if (rx_frame_o !== 8'h00) begin n_fail++; $display("FAIL reset_frame: got %h expected 00", rx_frame_o); end
    n_checks++;
    if (rx_parity_o !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b expected 0", rx_parity_o); end
    n_checks++;
    if (rx_frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", rx_frame_err_o); end
  endtask

  task automatic test_8n1();
    int lat;
    lat = (16 >> 1) + 16 * 9 + 1 + SYNC_LAT;
    set_cfg(16, 2'b00, 1'b0, 2'b00);
    clear_mon();
    hold_line(1'b1, 10);
    send_frame(8'hA5, 8, 0, 1'b0, 1, 16);
    hold_line(1'b1, 20);
    n_checks++;
    if (pulse_q.size() !== 1) begin n_fail++; $display("FAIL 8n1_pulses: got %0d expected 1", pulse_q.size()); end
    if (pulse_q.size() == 1) begin
      n_checks++;
      if (frame_q[0] !== 8'hA5) begin n_fail++; $display("FAIL 8n1_frame: got %h expected a5", frame_q[0]); end
      n_checks++;
      if (err_q[0] !== 1'b0) begin n_fail++; $display("FAIL 8n1_err: got %b expected 0", err_q[0]); end
      n_checks++;
      if (par_q[0] !== 1'b0) begin n_fail++; $display("FAIL 8n1_parity: got %b expected 0", par_q[0]); end
      n_checks++;
      if (pulse_q[0] - fall_q[0] !== lat) begin
        n_fail++; $display("FAIL 8n1_latency: got %0d expected %0d", pulse_q[0] - fall_q[0], lat);
      end
    end
  endtask

  task automatic test_7e2();
    int lat;
    lat = (16 >> 1) + 16 * (7 + 1 + 2) + 1 + SYNC_LAT;
    set_cfg(16, 2'b01, 1'b1, 2'b10);
    clear_mon();
    hold_line(1'b1, 10);
    send_frame(8'h35, 7, 1, 1'b0, 2, 16);
    hold_line(1'b1, 20);
    n_checks++;
    if (pulse_q.size() !== 1) begin n_fail++; $display("FAIL 7e2_pulses: got %0d expected 1", pulse_q.size()); end
    if (pulse_q.size() == 1) begin
      n_checks++;
      if (frame_q[0] !== 8'h35) begin n_fail++; $display("FAIL 7e2_frame: got %h expected 35", frame_q[0]); end
      n_checks++;
      if (par_q[0] !== 1'b0) begin n_fail++; $display("FAIL 7e2_parity: got %b expected 0", par_q[0]); end
      n_checks++;
      if (err_q[0] !== 1'b0) begin n_fail++; $display("FAIL 7e2_err: got %b expected 0", err_q[0]); end
      n_checks++;
      if (pulse_q[0] - fall_q[0] !== lat) begin
        n_fail++; $display("FAIL 7e2_latency: got %0d expected %0d", pulse_q[0] - fall_q[0], lat);
      end
    end
  endtask

  task automatic test_glitch();
    set_cfg(16, 2'b00, 1'b0, 2'b00);
    clear_mon();
    hold_line(1'b1, 5);
    hold_line(1'b0, 3);
    hold_line(1'b1, 40);
    n_checks++;
    if (pulse_q.size() !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d expected 0", pulse_q.size()); end
    clear_mon();
    send_frame(8'h3C, 8, 0, 1'b0, 1, 16);
    hold_line(1'b1, 20);
    n_checks++;
    if (pulse_q.size() !== 1) begin n_fail++; $display("FAIL glitch_next_pulses: got %0d expected 1", pulse_q.size()); end
    if (pulse_q.size() == 1) begin
      n_checks++;
      if (frame_q[0] !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_frame: got %h expected 3c", frame_q[0]); end
      n_checks++;
      if (err_q[0] !== 1'b0) begin n_fail++; $display("FAIL glitch_next_err: got %b expected 0", err_q[0]); end
    end
  endtask

  task automatic test_break();
    int lat;
    lat = (16 >> 1) + 16 * 9 + 1 + SYNC_LAT;
    set_cfg(16, 2'b00, 1'b0, 2'b00);
    clear_mon();
    fall_q.push_back(cyc);
    hold_line(1'b0, 20 * 16);
    hold_line(1'b1, 48);
    n_checks++;
    if (pulse_q.size() !== 1) begin n_fail++; $display("FAIL break_pulses: got %0d expected 1", pulse_q.size()); end
    if (pulse_q.size() == 1) begin
      n_checks++;
      if (frame_q[0] !== 8'h00) begin n_fail++; $display("FAIL break_frame: got %h expected 00", frame_q[0]); end
      n_checks++;
      if (err_q[0] !== 1'b1) begin n_fail++; $display("FAIL break_err: got %b expected 1", err_q[0]); end
      n_checks++;
      if (pulse_q[0] - fall_q[0] !== lat) begin
        n_fail++; $display("FAIL break_latency: got %0d expected %0d", pulse_q[0] - fall_q[0], lat);
      end
    end
    clear_mon();
    send_frame(8'h81, 8, 0, 1'b0, 1, 16);
    hold_line(1'b1, 20);
    n_checks++;
    if (pulse_q.size() !== 1) begin n_fail++; $display("FAIL break_next_pulses: got %0d expected 1", pulse_q.size()); end
    if (pulse_q.size() == 1) begin
      n_checks++;
      if (frame_q[0] !== 8'h81) begin n_fail++; $display("FAIL break_next_frame: got %h expected 81", frame_q[0]); end
      n_checks++;
      if (err_q[0] !== 1'b0) begin n_fail++; $display("FAIL break_next_err: got %b expected 0", err_q[0]); end
    end
  endtask

  task automatic test_frontend_reset();
    set_cfg(16, 2'b00, 1'b0, 2'b00);
    clear_mon();
    // Start bit plus the first three data bits of 0x5A, then abort
    hold_line(1'b0, 16);
    hold_line(1'b0, 16);
    hold_line(1'b1, 16);
    hold_line(1'b0, 16);
    uart_rx_i = 1'b1;
    frontend_rst_i = 1'b1;
    @(negedge clk_i);
    frontend_rst_i = 1'b0;
    n_checks++;
    if (rx_frame_o !== 8'h00) begin n_fail++; $display("FAIL srst_frame: got %h expected 00", rx_frame_o); end
    n_checks++;
    if (rx_frame_err_o !== 1'b0) begin n_fail++; $display("FAIL srst_err: got %b expected 0", rx_frame_err_o); end
    hold_line(1'b1, 300);
    n_checks++;
    if (pulse_q.size() !== 0) begin n_fail++; $display("FAIL srst_pulses: got %0d expected 0", pulse_q.size()); end
    n_checks++;
    if (rx_frame_o !== 8'h00) begin n_fail++; $display("FAIL srst_hold_frame: got %h expected 00", rx_frame_o); end
    clear_mon();
    send_frame(8'h5A, 8, 0, 1'b0, 1, 16);
    hold_line(1'b1, 20);
    n_checks++;
    if (pulse_q.size() !== 1) begin n_fail++; $display("FAIL srst_next_pulses: got %0d expected 1", pulse_q.size()); end
    if (pulse_q.size() == 1) begin
      n_checks++;
      if (frame_q[0] !== 8'h5A) begin n_fail++; $display("FAIL srst_next_frame: got %h expected 5a", frame_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    lat = (5 >> 1) + 5 * 9 + 1 + SYNC_LAT;
    set_cfg(5, 2'b00, 1'b0, 2'b00);
    clear_mon();
    hold_line(1'b1, 10);
    send_frame(8'h01, 8, 0, 1'b0, 1, 5);
    send_frame(8'hFF, 8, 0, 1'b0, 1, 5);
    hold_line(1'b1, 20);
    n_checks++;
    if (pulse_q.size() !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", pulse_q.size()); end
    if (pulse_q.size() == 2) begin
      n_checks++;
      if (frame_q[0] !== 8'h01) begin n_fail++; $display("FAIL b2b_frame0: got %h expected 01", frame_q[0]); end
      n_checks++;
      if (frame_q[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_frame1: got %h expected ff", frame_q[1]); end
      n_checks++;
      if ((err_q[0] | err_q[1]) !== 1'b0) begin
        n_fail++; $display("FAIL b2b_err: got %b%b expected 00", err_q[0], err_q[1]);
      end
      n_checks++;
      if (pulse_q[0] - fall_q[0] !== lat) begin
        n_fail++; $display("FAIL b2b_latency0: got %0d expected %0d", pulse_q[0] - fall_q[0], lat);
      end
      n_checks++;
      if (pulse_q[1] - fall_q[1] !== lat) begin
        n_fail++; $display("FAIL b2b_latency1: got %0d expected %0d", pulse_q[1] - fall_q[1], lat);
      end
    end
  endtask

  task automatic test_div_clamp();
    int lat;
    // A divider of 2 runs at 4 cycles per bit; 5 data bits, odd parity, one stop
    lat = (4 >> 1) + 4 * (5 + 1 + 1) + 1 + SYNC_LAT;
    set_cfg(2, 2'b11, 1'b0, 2'b11);
    clear_mon();
    hold_line(1'b1, 10);
    send_frame(8'h12, 5, 1, 1'b1, 1, 4);
    hold_line(1'b1, 20);
    n_checks++;
    if (pulse_q.size() !== 1) begin n_fail++; $display("FAIL clamp_pulses: got %0d expected 1", pulse_q.size()); end
    if (pulse_q.size() == 1) begin
      n_checks++;
      if (frame_q[0] !== 8'h12) begin n_fail++; $display("FAIL clamp_frame: got %h expected 12", frame_q[0]); end
      n_checks++;
      if (par_q[0] !== 1'b1) begin n_fail++; $display("FAIL clamp_parity: got %b expected 1", par_q[0]); end
      n_checks++;
      if (err_q[0] !== 1'b0) begin n_fail++; $display("FAIL clamp_err: got %b expected 0", err_q[0]); end
      n_checks++;
      if (pulse_q[0] - fall_q[0] !== lat) begin
        n_fail++; $display("FAIL clamp_latency: got %0d expected %0d", pulse_q[0] - fall_q[0], lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_glitch();
    test_break();
    test_frontend_reset();
    test_back_to_back();
    test_div_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
